// File: rtl/load_sequencer.sv
// load_sequencer: pops a 4-deep entry FIFO into up to four one-hot slots with timed load strobes, then issues a go strobe.
// Define LOAD_SEQ_AUTOGO_EN to go straight from the last gap to GO instead of waiting for the go input.
module load_sequencer #(
    parameter int STROBE_CYC = 5,
    parameter int GAP_CYC    = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [3:0] wr_data,
    input  logic       start,
    input  logic       go,
    output logic [3:0] partA,
    output logic [3:0] partB,
    output logic       partC,
    output logic       partD,
    output logic       busy,
    output logic       ovf
);
    typedef enum logic [2:0] {IDLE, SETUP, STROBE, GAP, WAIT_GO, GO} state_t;
`ifdef LOAD_SEQ_AUTOGO_EN
    localparam state_t END_ST = GO;
`else
    localparam state_t END_ST = WAIT_GO;
`endif
    state_t     r_state, w_next;
    logic [3:0] r_mem [4];
    logic [1:0] r_rd, r_wr, r_slot, w_ld_slot;
    logic [2:0] r_count;
    logic [3:0] r_tmr;
    logic       w_pop, w_push, w_tdone, w_more;

    always_comb begin
        w_tdone   = r_tmr == 4'd0;
        w_more    = r_count != 3'd0 && r_slot != 2'd3;
        w_next    = r_state;
        case (r_state)
            IDLE:    w_next = (start && r_count != 3'd0) ? SETUP : IDLE;
            SETUP:   w_next = STROBE;
            STROBE:  w_next = w_tdone ? GAP : STROBE;
            GAP:     w_next = w_tdone ? (w_more ? SETUP : END_ST) : GAP;
            WAIT_GO: w_next = go ? GO : WAIT_GO;
            GO:      w_next = w_tdone ? IDLE : GO;
            default: w_next = IDLE;
        endcase
        w_pop     = w_next == SETUP;
        w_push    = wr_en && (r_count != 3'd4 || w_pop);
        w_ld_slot = (r_state == IDLE) ? 2'd0 : r_slot + 2'd1;
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= wr_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_rd    <= 2'd0;
            r_wr    <= 2'd0;
            r_count <= 3'd0;
            r_slot  <= 2'd0;
            r_tmr   <= 4'd0;
            partA   <= 4'd0;
            partB   <= 4'd0;
            partC   <= 1'b0;
            partD   <= 1'b0;
            busy    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            r_state <= w_next;
            r_rd    <= r_rd + {1'b0, w_pop};
            r_wr    <= r_wr + {1'b0, w_push};
            r_count <= r_count + {2'b0, w_push} - {2'b0, w_pop};
            ovf     <= ovf | (wr_en && r_count == 3'd4 && !w_pop);
            // Each state entry reloads the timer; it only matters in STROBE, GAP and GO.
            if (w_next != r_state)
                r_tmr <= (w_next == GAP) ? 4'(GAP_CYC - 1) : 4'(STROBE_CYC - 1);
            else if (!w_tdone)
                r_tmr <= r_tmr - 4'd1;
            if (w_pop) begin
                partA  <= 4'b0001 << w_ld_slot;
                partB  <= r_mem[r_rd];
                r_slot <= w_ld_slot;
            end else if (w_next == WAIT_GO || w_next == GO || w_next == IDLE) begin
                partA <= 4'd0;
                partB <= 4'd0;
            end
            partC <= w_next == STROBE;
            partD <= w_next == GO;
            busy  <= w_next != IDLE;
        end
    end
endmodule

// File: tb/tb_load_sequencer.sv
// tb_load_sequencer: directed checks of the default (manual go) build with STROBE_CYC=5, GAP_CYC=10.
module tb_load_sequencer;
    logic       clk = 1'b0, reset = 1'b1, wr_en = 1'b0, start = 1'b0, go = 1'b0;
    logic [3:0] wr_data = 4'd0;
    logic [3:0] partA, partB;
    logic       partC, partD, busy, ovf;
    int         tests = 0, fails = 0;
    int         low, wt;

    load_sequencer dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .start(start), .go(go),
        .partA(partA), .partB(partB), .partC(partC), .partD(partD), .busy(busy), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] d);
        wr_en = 1'b1;
        wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic expect_load(input string tag, input logic [3:0] ea, input logic [3:0] eb, output int lo);
        int hi;
        logic [3:0] pa, pb;
        logic ok;
        lo = 0;
        pa = partA;
        pb = partB;
        while (partC !== 1'b1 && lo < 100) begin
            pa = partA;
            pb = partB;
            tick();
            lo++;
        end
        chk({tag, " partA"}, partA, ea);
        chk({tag, " partB"}, partB, eb);
        chk({tag, " setup_early"}, {pa, pb}, {ea, eb});
        hi = 0;
        ok = 1'b1;
        while (partC === 1'b1 && hi < 100) begin
            if (partA !== ea || partB !== eb || partD !== 1'b0 || busy !== 1'b1) ok = 1'b0;
            tick();
            hi++;
        end
        chk({tag, " strobe_len"}, hi, 5);
        chk({tag, " strobe_stable"}, ok, 1);
    endtask

    task automatic expect_go(input string tag, output int w);
        int hi;
        logic ok;
        w = 0;
        go = 1'b1;
        while (partD !== 1'b1 && w < 100) begin
            tick();
            w++;
        end
        go = 1'b0;
        hi = 0;
        ok = 1'b1;
        while (partD === 1'b1 && hi < 100) begin
            if (partA !== 4'd0 || partB !== 4'd0 || partC !== 1'b0 || busy !== 1'b1) ok = 1'b0;
            tick();
            hi++;
        end
        chk({tag, " go_len"}, hi, 5);
        chk({tag, " go_quiet"}, ok, 1);
        chk({tag, " busy_after"}, busy, 0);
    endtask

    initial begin
        logic ok;
        tick();
        tick();
        chk("reset outputs", {partA, partB, partC, partD, busy, ovf}, 0);
        reset = 1'b0;
        tick();

        // Fill the FIFO, then overflow it.
        push(4'h1);
        push(4'hA);
        push(4'h2);
        push(4'h5);
        chk("ovf before full push", ovf, 0);
        push(4'h7);
        chk("ovf after full push", ovf, 1);
        chk("idle busy", busy, 0);
        pulse_start();
        chk("setup busy", busy, 1);
        chk("setup partC", partC, 0);
        expect_load("r1 l0", 4'b0001, 4'h1, low);
        chk("r1 l0 latency", low, 1);
        expect_load("r1 l1", 4'b0010, 4'hA, low);
        chk("r1 l1 gap", low, 11);
        expect_load("r1 l2", 4'b0100, 4'h2, low);
        chk("r1 l2 gap", low, 11);
        expect_load("r1 l3", 4'b1000, 4'h5, low);
        chk("r1 l3 gap", low, 11);
        ok = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (partD !== 1'b0 || busy !== 1'b1 || partC !== 1'b0) ok = 1'b0;
            tick();
        end
        chk("wait_go hold", ok, 1);
        chk("wait_go partA", partA, 0);
        expect_go("r1", wt);
        chk("r1 go latency", wt, 1);

        // Start with an empty FIFO is ignored (the dropped word must not appear).
        pulse_start();
        chk("empty start busy", busy, 0);
        tick();
        chk("empty start partC", partC, 0);
        push(4'h3);
        push(4'h4);
        push(4'h5);
        pulse_start();
        expect_load("r2 l0", 4'b0001, 4'h3, low);
        expect_load("r2 l1", 4'b0010, 4'h4, low);
        expect_load("r2 l2", 4'b0100, 4'h5, low);
        expect_go("r2", wt);
        chk("ovf sticky", ovf, 1);

        // Asynchronous reset in the middle of the third strobe.
        push(4'h8);
        push(4'h9);
        push(4'hA);
        push(4'hB);
        pulse_start();
        expect_load("r3 l0", 4'b0001, 4'h8, low);
        expect_load("r3 l1", 4'b0010, 4'h9, low);
        wt = 0;
        while (partC !== 1'b1 && wt < 100) begin
            tick();
            wt++;
        end
        chk("r3 l2 rise", partC, 1);
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("async reset outputs", {partA, partB, partC, partD, busy, ovf}, 0);
        tick();
        reset = 1'b0;
        pulse_start();
        chk("post reset start busy", busy, 0);
        tick();
        chk("post reset partC", partC, 0);

        // Push on the same cycle as the first pop with a full FIFO.
        push(4'hA);
        push(4'hB);
        push(4'hC);
        push(4'hD);
        start = 1'b1;
        wr_en = 1'b1;
        wr_data = 4'hE;
        tick();
        start = 1'b0;
        wr_en = 1'b0;
        chk("push+pop ovf", ovf, 0);
        expect_load("r4 l0", 4'b0001, 4'hA, low);
        expect_load("r4 l1", 4'b0010, 4'hB, low);
        expect_load("r4 l2", 4'b0100, 4'hC, low);
        expect_load("r4 l3", 4'b1000, 4'hD, low);
        expect_go("r4", wt);
        pulse_start();
        expect_load("r5 l0", 4'b0001, 4'hE, low);
        expect_go("r5", wt);

        // A word pushed during the gap of a one-word run joins that run.
        push(4'h9);
        pulse_start();
        expect_load("r6 l0", 4'b0001, 4'h9, low);
        push(4'h6);
        expect_load("r6 l1", 4'b0010, 4'h6, low);
        expect_go("r6", wt);
        chk("final ovf", ovf, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
